// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Booth pair {Q[0], Q-1} encodings
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_controller_if.sv
// Operand/product handshake bundle between a producer/consumer and the Booth controller.
interface booth_seq_controller_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                   inValid;
  logic                   inReady;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   outValid;
  logic                   outReady;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output inValid, a, b, outReady,
    input  inReady, outValid, product, busy
  );

  modport slave (
    input  inValid, a, b, outReady,
    output inReady, outValid, product, busy
  );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub M per {Q[0],Q-1}, then arithmetic shift right.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             qm1_next
);

  logic [WIDTH:0] sum_s;

  // Add or subtract the multiplicand according to the Booth pair
  always_comb begin
    sum_s = acc;
    case ({q[0], qm1})
      BOOTH_ADD: sum_s = acc + m;
      BOOTH_SUB: sum_s = acc - m;
      BOOTH_NOP: sum_s = acc;
      default:   sum_s = acc;
    endcase
  end

  // Arithmetic shift of {A,Q,Q-1}; A's MSB is replicated
  always_comb begin
    acc_next = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_next   = {sum_s[0], q[WIDTH-1:1]};
    qm1_next = q[0];
  end

endmodule

// File: rtl/booth_seq_controller.sv
// Sequencing controller for a multi-cycle radix-2 Booth signed multiplier with valid/ready handshakes.
module booth_seq_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetN,
  booth_seq_controller_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic [WIDTH:0]       acc_r;
  logic [WIDTH-1:0]     q_r;
  logic                 qm1_r;
  logic [WIDTH:0]       m_r;
  logic [CW-1:0]        count_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH:0]       acc_next_s;
  logic [WIDTH-1:0]     q_next_s;
  logic                 qm1_next_s;
  logic                 accept_s;
  logic                 last_step_s;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .q        (q_r),
    .qm1      (qm1_r),
    .m        (m_r),
    .acc_next (acc_next_s),
    .q_next   (q_next_s),
    .qm1_next (qm1_next_s)
  );

  assign accept_s    = (state_r == ST_IDLE) && bus.inValid;
  assign last_step_s = (count_r == LAST_COUNT);

  // State register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.inValid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.outReady) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only (inReady also gated by reset)
  always_comb begin
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.busy     = 1'b0;
    case (state_r)
      ST_IDLE: bus.inReady  = resetN;
      ST_RUN:  bus.busy     = 1'b1;
      ST_DONE: begin
        bus.outValid = 1'b1;
        bus.busy     = 1'b1;
      end
      default: bus.inReady = 1'b0;
    endcase
  end

  assign bus.product = product_r;

  // Operand load, Booth iteration, counter and product capture
  always_ff @(posedge clk) begin
    if (!resetN) begin
      acc_r     <= '0;
      q_r       <= '0;
      qm1_r     <= 1'b0;
      m_r       <= '0;
      count_r   <= '0;
      product_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            m_r     <= {bus.a[WIDTH-1], bus.a};
            q_r     <= bus.b;
            acc_r   <= '0;
            qm1_r   <= 1'b0;
            count_r <= '0;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          q_r     <= q_next_s;
          qm1_r   <= qm1_next_s;
          count_r <= count_r + CW'(1);
          // Final step: product taken straight from the step outputs
          if (last_step_s) begin
            product_r <= {acc_next_s[WIDTH-1:0], q_next_s};
          end
        end
        ST_DONE: begin
          product_r <= product_r;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_controller.sv
// Directed self-checking bench for booth_seq_controller at WIDTH=32.
module tb_booth_seq_controller;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  booth_seq_controller_if #(.WIDTH(32)) bus ();

  booth_seq_controller #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair and advance past the accepting edge
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    int n;
    n = 0;
    while (bus.inReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    bus.a       = av;
    bus.b       = bv;
    bus.inValid = 1'b1;
    tick();
    bus.inValid = 1'b0;
  endtask

  // Count cycles until outValid, bounded
  task automatic wait_out(output int n);
    n = 0;
    while (bus.outValid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetN       = 1'b0;
    bus.inValid  = 1'b0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.outReady = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.inReady !== 1'b0) begin
      errors++; $display("FAIL reset_inready: got %0b expected 0", bus.inReady);
    end
    checks++;
    if (bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_outvalid_busy: got %0b/%0b expected 0/0", bus.outValid, bus.busy);
    end
    checks++;
    if (bus.product !== 64'd0) begin
      errors++; $display("FAIL reset_product: got %0h expected 0", bus.product);
    end
    resetN = 1'b1;
    tick();
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_inready: got %0b expected 1", bus.inReady);
    end
  endtask

  task automatic test_basic();
    int n;
    bus.outReady = 1'b1;
    start_op(32'd5, 32'd6);
    checks++;
    if (bus.busy !== 1'b1 || bus.inReady !== 1'b0) begin
      errors++; $display("FAIL basic_run_flags: got busy=%0b inReady=%0b expected 1/0", bus.busy, bus.inReady);
    end
    wait_out(n);
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL basic_latency: got %0d expected 32", n);
    end
    checks++;
    if (bus.product !== 64'd30) begin
      errors++; $display("FAIL basic_product: got %0h expected 1e", bus.product);
    end
    tick();
    checks++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      errors++; $display("FAIL basic_back_idle: got inReady=%0b outValid=%0b expected 1/0", bus.inReady, bus.outValid);
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] tp [4];
    int n;
    ta[0] = 32'hFFFF_FFFC; tb[0] = 32'hFFFF_FFF9; tp[0] = 64'd28;
    ta[1] = 32'd10;        tb[1] = 32'hFFFF_FFFC; tp[1] = 64'hFFFF_FFFF_FFFF_FFD8;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; tp[2] = 64'h4000_0000_0000_0000;
    ta[3] = 32'h8000_0000; tb[3] = 32'd1;         tp[3] = 64'hFFFF_FFFF_8000_0000;
    bus.outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i]);
      wait_out(n);
      checks++;
      if (n !== 32 || bus.product !== tp[i]) begin
        errors++;
        $display("FAIL signed_%0d: got product=%0h latency=%0d expected %0h/32", i, bus.product, n, tp[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.outReady = 1'b0;
    start_op(32'hFFFF_FFCE, 32'd5);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.outValid !== 1'b1 || bus.product !== 64'hFFFF_FFFF_FFFF_FF06) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got outValid=%0b product=%0h expected 1/ffffffffffffff06", i, bus.outValid, bus.product);
      end
      if (i < 4) tick();
    end
    bus.outReady = 1'b1;
    tick();
    checks++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got inReady=%0b outValid=%0b expected 1/0", bus.inReady, bus.outValid);
    end
  endtask

  task automatic test_ignore_during_run();
    int n;
    int extra;
    bus.outReady = 1'b1;
    start_op(32'd3, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    bus.a       = 32'd7;
    bus.b       = 32'd7;
    bus.inValid = 1'b1;
    tick();
    bus.inValid = 1'b0;
    wait_out(n);
    checks++;
    if (n + 6 !== 32 || bus.product !== 64'd9) begin
      errors++; $display("FAIL ignore_product: got product=%0h latency=%0d expected 9/32", bus.product, n + 6);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.outValid === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_no_second: got %0d outValid cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int seen;
    bus.outReady = 1'b1;
    start_op(32'd1234, 32'd99);
    for (int i = 0; i < 9; i++) tick();
    resetN = 1'b0;
    tick();
    checks++;
    if (bus.product !== 64'd0 || bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_state: got product=%0h outValid=%0b busy=%0b expected 0/0/0", bus.product, bus.outValid, bus.busy);
    end
    resetN = 1'b1;
    #1;
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++; $display("FAIL midrun_reset_idle: got inReady=%0b expected 1", bus.inReady);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.outValid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrun_no_outvalid: got %0d cycles expected 0", seen);
    end
    start_op(32'd99, 32'd1);
    wait_out(n);
    checks++;
    if (n !== 32 || bus.product !== 64'd99) begin
      errors++; $display("FAIL midrun_followup: got product=%0h latency=%0d expected 63/32", bus.product, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    bus.outReady = 1'b1;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.inValid  = 1'b1;
    tick();
    bus.a = 32'd32;
    bus.b = 32'd23;
    wait_out(n);
    checks++;
    if (n !== 32 || bus.product !== 64'd0) begin
      errors++; $display("FAIL b2b_first: got product=%0h latency=%0d expected 0/32", bus.product, n);
    end
    tick();
    checks++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got inReady=%0b outValid=%0b expected 1/0", bus.inReady, bus.outValid);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.inReady !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: got busy=%0b inReady=%0b expected 1/0", bus.busy, bus.inReady);
    end
    bus.inValid = 1'b0;
    wait_out(n);
    checks++;
    if (n !== 32 || bus.product !== 64'd736) begin
      errors++; $display("FAIL b2b_second: got product=%0h latency=%0d expected 2e0/32", bus.product, n);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_ignore_during_run();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
